// File: rtl/usb_rx_pkg.sv
// Shared constants, error codes, parser states and the CRC-8 byte update
// used by the USB receive packet parser (and later by the TX side).
package usb_rx_pkg;

    localparam logic [7:0] SOF      = 8'hA5;
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    localparam logic [2:0] ERR_LEN     = 3'b001;
    localparam logic [2:0] ERR_CRC     = 3'b010;
    localparam logic [2:0] ERR_TIMEOUT = 3'b011;
    localparam logic [2:0] ERR_OVERRUN = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID      = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC     = 3'd4,
        ST_REPLAY  = 3'd5
    } state_e;

    // CRC-8 over one byte, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc8_step.sv
// Combinational CRC-8 step: next CRC from the current CRC and one data byte.
module usb_crc8_step
    import usb_rx_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    assign crc_next = crc8_update(crc, data);

endmodule

// File: rtl/usb_rx_pck_parser.sv
// Delineates SOF/ID/LEN/payload/CRC packets from the decoded byte stream and
// replays CRC-clean payloads. Optional counters: define USB_RX_PCK_STATS_EN.
module usb_rx_pck_parser
    import usb_rx_pkg::*;
#(
    parameter int PAYLOAD_MAX = 16,
    parameter int TIMEOUT_CYC = 4800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       d_asserted,
    output logic [7:0] q,
    output logic [7:0] q_id,
    output logic [7:0] q_idx,
    output logic       q_valid,
    output logic       q_last,
    input  logic       q_ready,
    output logic       pck_ok,
    output logic [7:0] pck_id,
    output logic       pck_err,
    output logic [2:0] err_code,
    output logic       busy
`ifdef USB_RX_PCK_STATS_EN
    ,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int AW    = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [7:0]    PMAX     = 8'(PAYLOAD_MAX);

    state_e         state_q, state_d;
    logic [7:0]     id_q, id_d, len_q, len_d, crc_q, crc_d, idx_q, idx_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     pbuf_q [DEPTH];
    logic [7:0]     pbuf_d [DEPTH];
    logic [7:0]     q_q, q_d, q_id_q, q_id_d, q_idx_q, q_idx_d, pck_id_q, pck_id_d;
    logic           q_valid_q, q_valid_d, q_last_q, q_last_d;
    logic           pck_ok_q, pck_ok_d, pck_err_q, pck_err_d;
    logic [2:0]     err_code_q, err_code_d;
    logic [7:0]     crc_next_s, nidx_s;
    logic           timed_s, tmo_exp_s;

    usb_crc8_step u_crc (
        .crc      (crc_q),
        .data     (d),
        .crc_next (crc_next_s)
    );

    assign nidx_s    = idx_q + 8'd1;
    assign timed_s   = (state_q == ST_ID) || (state_q == ST_LEN) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
    assign tmo_exp_s = (TIMEOUT_CYC > 0) && (tmo_q == TMO_LAST);

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        len_d      = len_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        pbuf_d     = pbuf_q;
        q_d        = q_q;
        q_id_d     = q_id_q;
        q_idx_d    = q_idx_q;
        q_valid_d  = q_valid_q;
        q_last_d   = q_last_q;
        pck_ok_d   = 1'b0;
        pck_id_d   = pck_id_q;
        pck_err_d  = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (d_asserted && (d == SOF)) begin
                    state_d = ST_ID;
                    crc_d   = CRC_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ID: begin
                if (d_asserted) begin
                    id_d    = d;
                    crc_d   = crc_next_s;
                    state_d = ST_LEN;
                end else begin
                    state_d = ST_ID;
                end
            end
            ST_LEN: begin
                if (d_asserted) begin
                    len_d = d;
                    crc_d = crc_next_s;
                    idx_d = 8'd0;
                    if (d > PMAX) begin
                        state_d    = ST_IDLE;
                        pck_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (d == 8'd0) begin
                        state_d = ST_CRC;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (d_asserted) begin
                    pbuf_d[idx_q[AW-1:0]] = d;
                    crc_d = crc_next_s;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = ST_CRC;
                    end else begin
                        idx_d = nidx_s;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CRC: begin
                if (d_asserted) begin
                    if (d != crc_q) begin
                        state_d    = ST_IDLE;
                        pck_err_d  = 1'b1;
                        err_code_d = ERR_CRC;
                    end else if (len_q == 8'd0) begin
                        state_d  = ST_IDLE;
                        pck_ok_d = 1'b1;
                        pck_id_d = id_q;
                    end else begin
                        state_d   = ST_REPLAY;
                        idx_d     = 8'd0;
                        q_valid_d = 1'b1;
                        q_d       = pbuf_q[0];
                        q_id_d    = id_q;
                        q_idx_d   = 8'd0;
                        q_last_d  = (len_q == 8'd1);
                    end
                end else begin
                    state_d = ST_CRC;
                end
            end
            ST_REPLAY: begin
                // A byte arriving now has nowhere to go; report and drop it.
                if (d_asserted) begin
                    pck_err_d  = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end else begin
                    pck_err_d = 1'b0;
                end
                if (q_valid_q && q_ready) begin
                    if (q_last_q) begin
                        state_d   = ST_IDLE;
                        q_valid_d = 1'b0;
                        q_last_d  = 1'b0;
                        pck_ok_d  = 1'b1;
                        pck_id_d  = id_q;
                    end else begin
                        idx_d    = nidx_s;
                        q_d      = pbuf_q[nidx_s[AW-1:0]];
                        q_idx_d  = nidx_s;
                        q_last_d = (nidx_s == (len_q - 8'd1));
                    end
                end else begin
                    state_d = ST_REPLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Inter-byte timeout; an arriving byte always beats expiry.
        if (!timed_s) begin
            if (state_d != state_q) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q;
            end
        end else if (d_asserted) begin
            tmo_d = '0;
        end else if (tmo_exp_s) begin
            tmo_d      = '0;
            state_d    = ST_IDLE;
            pck_err_d  = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            id_q       <= 8'd0;
            len_q      <= 8'd0;
            crc_q      <= CRC_INIT;
            idx_q      <= 8'd0;
            tmo_q      <= '0;
            q_q        <= 8'd0;
            q_id_q     <= 8'd0;
            q_idx_q    <= 8'd0;
            q_valid_q  <= 1'b0;
            q_last_q   <= 1'b0;
            pck_ok_q   <= 1'b0;
            pck_id_q   <= 8'd0;
            pck_err_q  <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            q_q        <= q_d;
            q_id_q     <= q_id_d;
            q_idx_q    <= q_idx_d;
            q_valid_q  <= q_valid_d;
            q_last_q   <= q_last_d;
            pck_ok_q   <= pck_ok_d;
            pck_id_q   <= pck_id_d;
            pck_err_q  <= pck_err_d;
            err_code_q <= err_code_d;
        end
    end

    // Payload buffer; contents are only meaningful once a packet is written.
    always_ff @(posedge clk) begin
        pbuf_q <= pbuf_d;
    end

    assign q        = q_q;
    assign q_id     = q_id_q;
    assign q_idx    = q_idx_q;
    assign q_valid  = q_valid_q;
    assign q_last   = q_last_q;
    assign pck_ok   = pck_ok_q;
    assign pck_id   = pck_id_q;
    assign pck_err  = pck_err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef USB_RX_PCK_STATS_EN
    logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

    // Saturating event counters.
    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (pck_ok_q && (ok_cnt_q != 16'hFFFF)) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end else begin
            ok_cnt_d = ok_cnt_q;
        end
        if (pck_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ok_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ok_cnt  = ok_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule
